// File: rtl/future_pkg.sv
// Purpose: shared FUTURE cipher types, widths and the lane XOR helper.
// Latency: n/a (types, constants and a combinational function only).
// Backpressure: n/a.
// Contents: FUTURE_BLOCK_W block width, state_t engine states, xor_lane().
package future_pkg;

  localparam int FUTURE_BLOCK_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // XORs a and b, then moves lane idx (lane_w bits wide, big-endian lane
  // numbering) up to bits [0:lane_w-1]. The caller slices [0 +: lane_w].
  // Operands narrower than the block are left-aligned by the caller.
  function automatic logic [0:FUTURE_BLOCK_W-1] xor_lane(
    input logic [0:FUTURE_BLOCK_W-1] a,
    input logic [0:FUTURE_BLOCK_W-1] b,
    input int unsigned               idx,
    input int unsigned               lane_w
  );
    return (a ^ b) << (idx * lane_w);
  endfunction

endpackage

// File: rtl/xor_lane_engine.sv
// Purpose: sequential XOR of operand A with B (or with the last delivered result), LANE_W bits per clock.
// Latency: accept edge + DATA_W/LANE_W edges, then result held in DONE; one block per NLANES+2 cycles.
// Backpressure: result held stable while out_ready=0; in_ready is low whenever a block is in flight.
// Ports: clk/rst (sync, active high); in_valid/in_ready/in_a/in_b/in_chain operand side;
//        out_valid/out_ready/out_c result side; busy high in RUN or DONE.
module xor_lane_engine
  import future_pkg::*;
#(
  parameter int DATA_W = FUTURE_BLOCK_W,
  parameter int LANE_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:DATA_W-1] in_a,
  input  logic [0:DATA_W-1] in_b,
  input  logic              in_chain,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:DATA_W-1] out_c,
  output logic              busy
);

  localparam int NLANES = DATA_W / LANE_W;
  localparam int CNT_W  = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NLANES - 1);

  generate
    if (LANE_W < 1 || LANE_W > DATA_W || (DATA_W % LANE_W) != 0 || DATA_W > FUTURE_BLOCK_W) begin : g_bad_params
      $error("xor_lane_engine: LANE_W must divide DATA_W, and DATA_W must not exceed FUTURE_BLOCK_W");
    end
  endgenerate

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [0:DATA_W-1] a_q, b_q, res_q, last_c_q;
  logic [0:FUTURE_BLOCK_W-1] a_ext, b_ext, lane_xor;
  logic last_lane;

  assign last_lane = (cnt_q == LAST_LANE);

  // Operands are left-aligned into the block-wide helper so lane 0 stays at bit 0.
  always_comb begin
    a_ext = '0;
    b_ext = '0;
    a_ext[0 +: DATA_W] = a_q;
    b_ext[0 +: DATA_W] = b_q;
    lane_xor = xor_lane(a_ext, b_ext, 32'(cnt_q), 32'(LANE_W));
  end

  // Outputs decode the registered state only, so there is no
  // combinational path from in_valid or out_ready to the handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_lane) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_c = res_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      last_c_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= in_a;
            b_q   <= in_chain ? last_c_q : in_b;
            cnt_q <= '0;
          end
        end
        RUN: begin
          res_q[int'(cnt_q) * LANE_W +: LANE_W] <= lane_xor[0 +: LANE_W];
          cnt_q <= last_lane ? '0 : cnt_q + CNT_W'(1);
        end
        DONE: begin
          // Only a delivered result becomes the chain operand.
          if (out_ready) last_c_q <= res_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_lane_engine.sv
module tb_xor_lane_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // ---------------- directed instance (default LANE_W=16) ----------------
  logic        rst, in_valid, in_ready, in_chain, out_valid, out_ready, busy;
  logic [0:63] in_a, in_b, out_c;

  xor_lane_engine #(.DATA_W(64), .LANE_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_chain(in_chain),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c),
    .busy(busy)
  );

  logic [0:63] exp_q[$];
  logic [0:63] mon_exp;
  int          hs_cnt = 0;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'(1), 64'(0));
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", out_c, mon_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [0:63] a, input logic [0:63] b, input logic ch,
                       input logic [0:63] exp, input bit push);
    int k = 0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    check("issue_in_ready", 64'(in_ready), 64'(1));
    in_a = a;
    in_b = b;
    in_chain = ch;
    in_valid = 1'b1;
    if (push) exp_q.push_back(exp);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  // ---------------- parameter sweep instances ----------------
  typedef struct {
    logic [0:63] c;
    int          acc;
  } sw_item_t;

  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int LW = (g == 0) ? 64 : 8;
    localparam int NL = 64 / LW;

    logic        s_rst, s_iv, s_ir, s_ch, s_ov, s_or, s_busy;
    logic [0:63] s_a, s_b, s_c;
    sw_item_t    q[$];
    sw_item_t    m;
    int          last_hs = -1;
    bit          done = 1'b0;

    xor_lane_engine #(.DATA_W(64), .LANE_W(LW)) u_dut (
      .clk(clk), .rst(s_rst),
      .in_valid(s_iv), .in_ready(s_ir),
      .in_a(s_a), .in_b(s_b), .in_chain(s_ch),
      .out_valid(s_ov), .out_ready(s_or), .out_c(s_c),
      .busy(s_busy)
    );

    initial begin
      int k;
      s_rst = 1'b1; s_iv = 1'b0; s_ch = 1'b0; s_or = 1'b1;
      s_a = '0; s_b = '0;
      repeat (2) @(posedge clk);
      #1;
      s_rst = 1'b0;
      s_iv  = 1'b1;
      for (int i = 0; i < 1000; i++) begin
        k = 0;
        while (!s_ir && k < 100) begin
          @(posedge clk); #1;
          k++;
        end
        if (!s_ir) begin
          check($sformatf("sweep_lw%0d_ready_timeout", LW), 64'(0), 64'(1));
          break;
        end
        s_a = {$urandom, $urandom};
        s_b = {$urandom, $urandom};
        q.push_back('{c: s_a ^ s_b, acc: cyc + 1});
        @(posedge clk); #1;
      end
      s_iv = 1'b0;
      k = 0;
      while (q.size() != 0 && k < 100) begin
        @(posedge clk); #1;
        k++;
      end
      check($sformatf("sweep_lw%0d_drained", LW), 64'(q.size()), 64'(0));
      done = 1'b1;
    end

    always @(negedge clk) begin
      if (!s_rst && s_ov && s_or) begin
        if (q.size() == 0) begin
          check($sformatf("sweep_lw%0d_unexpected", LW), 64'(1), 64'(0));
        end else begin
          m = q.pop_front();
          check($sformatf("sweep_lw%0d_data", LW), s_c, m.c);
          check($sformatf("sweep_lw%0d_latency", LW), 64'(cyc - m.acc), 64'(NL));
        end
        if (last_hs >= 0)
          check($sformatf("sweep_lw%0d_period", LW), 64'(cyc - last_hs), 64'(NL + 2));
        last_hs = cyc;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  localparam logic [0:63] BP_EXP = 64'hfedc_4567_7654_cdef;

  initial begin
    int lat;
    int hs0;
    int k;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_chain = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready",  64'(in_ready),  64'(1));
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_busy",      64'(busy),      64'(0));
    check("reset_out_c",     out_c,          64'(0));
    tick();

    // basic XOR
    out_ready = 1'b1;
    issue(64'h3423_6732_abcd_2331, 64'h1, 1'b0, 64'h3423_6732_abcd_2330, 1'b1);
    wait_valid(lat);
    check("basic_latency", 64'(lat), 64'(4));
    tick();

    // chain: in_b must be ignored
    issue(64'h0000_0000_0000_00FF, '1, 1'b1, 64'h3423_6732_abcd_23CF, 1'b1);
    wait_valid(lat);
    check("chain_latency", 64'(lat), 64'(4));
    tick();

    // backpressure in DONE while in_valid pulses
    out_ready = 1'b0;
    issue(64'h0123_4567_89ab_cdef, 64'hffff_0000_ffff_0000, 1'b0, BP_EXP, 1'b1);
    wait_valid(lat);
    check("bp_latency", 64'(lat), 64'(4));
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_a = 64'(i) * 64'h0101_0101_0101_0101;
      in_b = ~in_a;
      in_chain = 1'b0;
      @(negedge clk);
      check("bp_out_c_stable", out_c, BP_EXP);
      check("bp_in_ready_low", 64'(in_ready), 64'(0));
      check("bp_out_valid_held", 64'(out_valid), 64'(1));
      tick();
    end
    in_valid = 1'b0;
    hs0 = hs_cnt;
    out_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("bp_one_handshake", 64'(hs_cnt - hs0), 64'(1));
    check("bp_idle_in_ready", 64'(in_ready), 64'(1));
    check("bp_idle_busy", 64'(busy), 64'(0));
    tick();

    // chain off the backpressured result proves no pulsed operand was captured
    issue(64'h1, 64'h0, 1'b1, 64'hfedc_4567_7654_cdee, 1'b1);
    wait_valid(lat);
    check("bp_chain_latency", 64'(lat), 64'(4));
    tick();

    // reset after lanes 0 and 1 are processed; the block must never appear
    issue(64'hdead_beef_0000_1111, 64'h5555_5555_5555_5555, 1'b0, '0, 1'b0);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", 64'(out_valid), 64'(0));
    check("rst_mid_busy",      64'(busy),      64'(0));
    check("rst_mid_in_ready",  64'(in_ready),  64'(1));
    check("rst_mid_out_c",     out_c,          64'(0));
    tick();
    issue(64'hFF, 64'h1234, 1'b1, 64'hFF, 1'b1);
    wait_valid(lat);
    check("rst_chain_latency", 64'(lat), 64'(4));
    tick(); tick();
    check("directed_queue_empty", 64'(exp_q.size()), 64'(0));

    k = 0;
    while (!(g_sweep[0].done && g_sweep[1].done) && k < 20000) begin
      tick();
      k++;
    end
    check("sweep_finished", 64'(g_sweep[0].done && g_sweep[1].done), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xor_lane_engine.md
# xor_lane_engine

Parametrised, sequential successor to the FUTURE cipher's combinational 64-bit XOR stage, used for key whitening and AddRoundKey. It XORs operand A with operand B, or with its own previous result in chain mode, processing LANE_W bits per clock to trade area for latency. Operands arrive and results leave over valid/ready handshakes, so the block can sit between the round-key generator and the round datapath.

## Interface
- DATA_W, 64, block width in bits; bit 0 is the MSB (big-endian [0:DATA_W-1] indexing)
- LANE_W, 16, bits XORed per cycle; must divide DATA_W; LANE_W == DATA_W is legal
- clk  in  1  clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands presented
- in_ready  out  1  engine can accept operands
- in_a  in  DATA_W  operand A
- in_b  in  DATA_W  operand B; ignored when in_chain=1
- in_chain  in  1  use last delivered result as operand B
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_c  out  DATA_W  result
- busy  out  1  high in RUN or DONE

## Operation
- NLANES = DATA_W/LANE_W. Elaboration fails if DATA_W % LANE_W != 0 or LANE_W > DATA_W.
- The state machine has three states: IDLE, RUN and DONE. Reset state is IDLE.
- IDLE: in_ready=1. On in_valid, capture in_a into the A register and capture B (in_b, or last_c if in_chain). Clear the lane counter and go to RUN.
- RUN: at each edge, res[lane*LANE_W +: LANE_W] = A-lane XOR B-lane and the counter increments. Lane 0 covers bits [0:LANE_W-1].
- RUN exits to DONE on the edge that processes lane NLANES-1. The counter returns to 0 there and never exceeds NLANES-1.
- DONE: out_valid=1 and out_c=res, held stable until out_ready. On out_ready, last_c is set to res and the state goes to IDLE.
- In RUN and DONE, in_ready=0. in_valid is ignored and its operands are not captured.
- Chain with no prior delivered result uses last_c=0, so the result equals in_a.
- out_c always shows res. Its contents during RUN are partial and are not checked by the bench.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, out_c=0, last_c=0, counter=0, state IDLE.
- rst asserted in any state (including mid-RUN or in DONE with out_valid high) returns to reset values at the next edge. The in-flight block is discarded and never delivered. last_c is cleared.
- Latency: the accept edge is E0. Lanes are processed at E1..EN, and out_valid is high in the cycle following EN. For the defaults, out_valid rises 4 cycles after the accept edge.
- Throughput with out_ready held high and in_valid held high: one block per NLANES+2 cycles (RUN NLANES cycles, DONE 1 cycle, IDLE 1 cycle).
- out_valid stays high and out_c stays unchanged under backpressure for any number of cycles.
- There is no combinational path from in_valid to in_ready or from out_ready to out_valid.

## Structure
- Shared package future_pkg holds FUTURE_BLOCK_W=64 and the state enum {IDLE, RUN, DONE}.
- Implemented as a single module with no sub-module. Lane select and XOR are a package function xor_lane(a, b, idx), reusable by the round datapath.

## Test plan
- Basic: in_a=64'h3423_6732_abcd_2331, in_b=64'h1, chain=0, out_ready=1. Required: out_valid 4 cycles after accept, out_c=64'h3423_6732_abcd_2330.
- Chain: follow the basic case with in_a=64'h0000_0000_0000_00FF, in_chain=1, in_b=all-ones (must be ignored). Required: out_c=64'h3423_6732_abcd_23CF.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while pulsing in_valid. Required: out_c stable, in_ready=0, no operand capture; on release, exactly one handshake, then IDLE.
- Reset mid-RUN: assert rst after lanes 0-1 are processed. Required: next cycle shows out_valid=0, busy=0, in_ready=1, out_c=0. A subsequent chain op with in_a=64'hFF returns 64'hFF.
- Parameter sweep: LANE_W=64 gives 1-cycle latency; LANE_W=8 gives 8-cycle latency. Random a/b over 1000 blocks per configuration must match a^b, with back-to-back period NLANES+2.
